uart_rx_controller: RTL

//   Receive side of the UART link. Recovers 8N1 frames (optional parity) from the serial line rxd.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame geometry
// (the defaults are also used by the TX controller).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd pad plus a falling-edge detect on the synced line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxs,
    output logic fall
);

    logic meta_q;
    logic rxs_q;
    logic prev_q;

    // All stages reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd;
            rxs_q  <= meta_q;
            prev_q <= rxs_q;
        end
    end

    assign rxs  = rxs_q;
    assign fall = prev_q & ~rxs_q;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: oversampled 8N1 frame recovery into a 1-deep valid/ready holding register.
// Optional parity bit and check enabled by defining UART_RX_PARITY_EN.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rxd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] MID_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] END_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_controller: OVERSAMPLE must be even and >= 4, PARITY_ODD must be 0 or 1");
    end

    logic rxs;
    logic fall;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .rxs  (rxs),
        .fall (fall)
    );

    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 par_fault;
    logic                 stop_sample;
    logic                 commit;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic perr_q;
    assign par_fault = par_bad_q;
`else
    assign par_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end
            ST_START: begin
                if (rx_tick) begin
                    if (tick_q == MID_TICK) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (rx_tick) begin
                    if (tick_q == END_TICK) begin
                        tick_d  = '0;
                        shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) state_d = AFTER_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (rx_tick) begin
                    if (tick_q == END_TICK) begin
                        tick_d    = '0;
                        par_bad_d = rxs ^ (^shreg_q) ^ 1'(PARITY_ODD);
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (rx_tick) begin
                    if (tick_q == END_TICK) state_d = ST_IDLE;
                    else                    tick_d  = tick_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stop_sample = (state_q == ST_STOP) && rx_tick && (tick_q == END_TICK);
    assign commit      = stop_sample & rxs & ~par_fault;
    assign ferr_d      = stop_sample & ~rxs;

    // A commit coinciding with a handshake refills the register without dropping valid.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (commit && (!valid_q || rx_ready)) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
        end else if (commit) begin
            ovr_d = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= stop_sample & par_bad_q;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
